// File: rtl/serial_addsub_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder/subtractor.
//   state_e      : transaction FSM states
//   calc_nstep   : number of DIGIT-wide steps per WIDTH-bit operand
//   calc_step_w  : step counter width, clog2(NSTEP) but never below 1
package serial_addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Guarded against DIGIT=0 so a bad parameter reaches the top-level check.
   function automatic int unsigned calc_nstep(input int unsigned width,
                                              input int unsigned digit);
      if (digit == 0) return 1;
      return width / digit;
   endfunction

   function automatic int unsigned calc_step_w(input int unsigned nstep);
      if (nstep <= 1) return 1;
      return $clog2(nstep);
   endfunction

endpackage

// File: rtl/serial_addsub_digit.sv
// Combinational DIGIT-bit ripple-carry slice used once per clock by the
// serial adder/subtractor.
//   x, y : operand slices (y already inverted by the caller for subtraction)
//   ci   : carry into the slice LSB
//   s    : slice sum
//   co   : carry out of the slice MSB
module addsub_digit #(
   parameter int unsigned DIGIT = 2
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             ci,
   output logic [DIGIT-1:0] s,
   output logic             co
);

   logic [DIGIT:0] w_carry;

   // Bit-level ripple through the slice.
   always_comb begin
      w_carry    = '0;
      s          = '0;
      w_carry[0] = ci;
      for (int i = 0; i < int'(DIGIT); i++) begin
         s[i]         = x[i] ^ y[i] ^ w_carry[i];
         w_carry[i+1] = (x[i] & y[i]) | (w_carry[i] & (x[i] ^ y[i]));
      end
   end

   assign co = w_carry[DIGIT];

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: accepts one WIDTH-bit operand pair over a
// valid/ready handshake, processes DIGIT bits per clock LSB first, and
// returns the result with carry/borrow-out and signed overflow.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (a, b, cin, sub)
//   a, b                : operands
//   cin                 : carry-in (add) / borrow-in (sub)
//   sub                 : 0 = a+b+cin, 1 = a-b-cin
//   out_valid/out_ready : result handshake
//   res, cout, ovf      : result, carry/borrow-out, signed overflow
module serial_addsub
   import serial_addsub_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIGIT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] res,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned NSTEP  = calc_nstep(WIDTH, DIGIT);
   localparam int unsigned STEP_W = calc_step_w(NSTEP);
   localparam int unsigned IDX_W  = $clog2(WIDTH);
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NSTEP - 1);

   // Reject illegal geometry at elaboration.
   if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
   end

   state_e              r_state;
   state_e              w_state_nxt;
   logic                w_accept;
   logic                w_last;

   logic [WIDTH-1:0]    r_a;
   logic [WIDTH-1:0]    r_b;        // b, or ~b when subtracting
   logic                r_b_msb;    // MSB of the original b for overflow
   logic                r_sub;
   logic                r_carry;
   logic [STEP_W-1:0]   r_step;
   logic [WIDTH-1:0]    r_res;
   logic                r_cout;
   logic                r_ovf;
   logic                r_out_valid;

   logic [IDX_W-1:0]    w_base;
   logic [DIGIT-1:0]    w_x;
   logic [DIGIT-1:0]    w_y;
   logic [DIGIT-1:0]    w_s;
   logic                w_co;
   logic                w_res_msb;
   logic                w_ovf;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next state and handshake decode; in_ready is held low during reset.
   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      w_accept    = 1'b0;
      w_last      = 1'b0;
      unique case (r_state)
         IDLE: begin
            in_ready = !rst;
            w_accept = in_valid && !rst;
            if (w_accept) w_state_nxt = RUN;
         end
         RUN: begin
            w_last = (r_step == LAST_STEP);
            if (w_last) w_state_nxt = DONE;
         end
         DONE: begin
            if (out_ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Current digit slices of the latched operands.
   assign w_base = IDX_W'(32'(r_step) * DIGIT);
   assign w_x    = r_a[w_base +: DIGIT];
   assign w_y    = r_b[w_base +: DIGIT];

   addsub_digit #(
      .DIGIT (DIGIT)
   ) u_digit (
      .x  (w_x),
      .y  (w_y),
      .ci (r_carry),
      .s  (w_s),
      .co (w_co)
   );

   // On the last step the slice MSB is the result MSB.
   assign w_res_msb = w_s[DIGIT-1];
   assign w_ovf = r_sub ? ((r_a[WIDTH-1] != r_b_msb) && (w_res_msb != r_a[WIDTH-1]))
                        : ((r_a[WIDTH-1] == r_b_msb) && (w_res_msb != r_a[WIDTH-1]));

   // Operand latch, serial datapath and result flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a         <= '0;
         r_b         <= '0;
         r_b_msb     <= 1'b0;
         r_sub       <= 1'b0;
         r_carry     <= 1'b0;
         r_step      <= '0;
         r_res       <= '0;
         r_cout      <= 1'b0;
         r_ovf       <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= (w_state_nxt == DONE);
         if (w_accept) begin
            // Subtraction as a + ~b + !cin.
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_b_msb <= b[WIDTH-1];
            r_sub   <= sub;
            r_carry <= sub ? ~cin : cin;
            r_step  <= '0;
            r_res   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
         end else if (r_state == RUN) begin
            r_res[w_base +: DIGIT] <= w_s;
            r_carry                <= w_co;
            r_step                 <= w_last ? '0 : r_step + STEP_W'(1);
            if (w_last) begin
               r_cout <= r_sub ? ~w_co : w_co;
               r_ovf  <= w_ovf;
            end
         end
      end
   end

   assign out_valid = r_out_valid;
   assign res       = r_res;
   assign cout      = r_cout;
   assign ovf       = r_ovf;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub: three instances (4/1, 4/2, 8/2).
module tb_serial_addsub;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   // WIDTH=8, DIGIT=2
   logic       v8_in_valid, v8_in_ready, v8_out_valid, v8_out_ready;
   logic       v8_cin, v8_sub, v8_cout, v8_ovf;
   logic [7:0] v8_a, v8_b, v8_res;
   // WIDTH=4, DIGIT=1
   logic       q1_in_valid, q1_in_ready, q1_out_valid, q1_out_ready;
   logic       q1_cin, q1_sub, q1_cout, q1_ovf;
   logic [3:0] q1_a, q1_b, q1_res;
   // WIDTH=4, DIGIT=2
   logic       q2_in_valid, q2_in_ready, q2_out_valid, q2_out_ready;
   logic       q2_cin, q2_sub, q2_cout, q2_ovf;
   logic [3:0] q2_a, q2_b, q2_res;

   int passed = 0;
   int total  = 0;

   serial_addsub #(.WIDTH(8), .DIGIT(2)) u_v8 (
      .clk(clk), .rst(rst), .in_valid(v8_in_valid), .in_ready(v8_in_ready),
      .a(v8_a), .b(v8_b), .cin(v8_cin), .sub(v8_sub),
      .out_valid(v8_out_valid), .out_ready(v8_out_ready),
      .res(v8_res), .cout(v8_cout), .ovf(v8_ovf));

   serial_addsub #(.WIDTH(4), .DIGIT(1)) u_q1 (
      .clk(clk), .rst(rst), .in_valid(q1_in_valid), .in_ready(q1_in_ready),
      .a(q1_a), .b(q1_b), .cin(q1_cin), .sub(q1_sub),
      .out_valid(q1_out_valid), .out_ready(q1_out_ready),
      .res(q1_res), .cout(q1_cout), .ovf(q1_ovf));

   serial_addsub #(.WIDTH(4), .DIGIT(2)) u_q2 (
      .clk(clk), .rst(rst), .in_valid(q2_in_valid), .in_ready(q2_in_ready),
      .a(q2_a), .b(q2_b), .cin(q2_cin), .sub(q2_sub),
      .out_valid(q2_out_valid), .out_ready(q2_out_ready),
      .res(q2_res), .cout(q2_cout), .ovf(q2_ovf));

   // Drivers: one transaction each, starting with the DUT in IDLE.
   task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                       input logic s, output logic [7:0] r, output logic co,
                       output logic ov, output int lat);
      v8_a = a; v8_b = b; v8_cin = ci; v8_sub = s; v8_in_valid = 1'b1;
      @(posedge clk); #1;
      v8_in_valid = 1'b0;
      lat = 0;
      while (!v8_out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
      r = v8_res; co = v8_cout; ov = v8_ovf;
      v8_out_ready = 1'b1;
      @(posedge clk); #1;
      v8_out_ready = 1'b0;
   endtask

   task automatic run4a(input logic [3:0] a, input logic [3:0] b, input logic ci,
                        input logic s, output logic [3:0] r, output logic co,
                        output logic ov, output int lat);
      q1_a = a; q1_b = b; q1_cin = ci; q1_sub = s; q1_in_valid = 1'b1;
      @(posedge clk); #1;
      q1_in_valid = 1'b0;
      lat = 0;
      while (!q1_out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
      r = q1_res; co = q1_cout; ov = q1_ovf;
      q1_out_ready = 1'b1;
      @(posedge clk); #1;
      q1_out_ready = 1'b0;
   endtask

   task automatic run4b(input logic [3:0] a, input logic [3:0] b, input logic ci,
                        input logic s, output logic [3:0] r, output logic co,
                        output logic ov, output int lat);
      q2_a = a; q2_b = b; q2_cin = ci; q2_sub = s; q2_in_valid = 1'b1;
      @(posedge clk); #1;
      q2_in_valid = 1'b0;
      lat = 0;
      while (!q2_out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
      r = q2_res; co = q2_cout; ov = q2_ovf;
      q2_out_ready = 1'b1;
      @(posedge clk); #1;
      q2_out_ready = 1'b0;
   endtask

   task automatic test_reset();
      total++; if (v8_in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", v8_in_ready); else passed++;
      total++; if (v8_out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", v8_out_valid); else passed++;
      total++; if ({v8_res, v8_cout, v8_ovf} !== 10'd0) $display("FAIL rst_outputs: got %h want 000", {v8_res, v8_cout, v8_ovf}); else passed++;
      total++; if (q1_in_ready !== 1'b0) $display("FAIL rst_q1_in_ready: got %b want 0", q1_in_ready); else passed++;
      rst = 1'b0;
      #1;
      total++; if (v8_in_ready !== 1'b1) $display("FAIL post_rst_in_ready: got %b want 1", v8_in_ready); else passed++;
      total++; if ({q1_in_ready, q2_in_ready} !== 2'b11) $display("FAIL post_rst_q_in_ready: got %b want 11", {q1_in_ready, q2_in_ready}); else passed++;
      @(posedge clk); #1;
   endtask

   task automatic test_w4_d1();
      logic [3:0] r; logic co, ov; int lat;
      run4a(4'b1010, 4'b0101, 1'b0, 1'b0, r, co, ov, lat);
      total++; if (lat !== 4) $display("FAIL w4d1_latency: got %0d want 4", lat); else passed++;
      total++; if (r !== 4'b1111) $display("FAIL w4d1_res: got %b want 1111", r); else passed++;
      total++; if ({co, ov} !== 2'b00) $display("FAIL w4d1_flags: got %b want 00", {co, ov}); else passed++;
   endtask

   task automatic test_w4_d2();
      logic [3:0] r; logic co, ov; int lat;
      run4b(4'b0111, 4'b0001, 1'b0, 1'b0, r, co, ov, lat);
      total++; if (lat !== 2) $display("FAIL w4d2_latency: got %0d want 2", lat); else passed++;
      total++; if (r !== 4'b1000) $display("FAIL w4d2_res1: got %b want 1000", r); else passed++;
      total++; if ({co, ov} !== 2'b01) $display("FAIL w4d2_flags1: got %b want 01", {co, ov}); else passed++;
      run4b(4'b1111, 4'b0001, 1'b1, 1'b0, r, co, ov, lat);
      total++; if (r !== 4'b0001) $display("FAIL w4d2_res2: got %b want 0001", r); else passed++;
      total++; if ({co, ov} !== 2'b10) $display("FAIL w4d2_flags2: got %b want 10", {co, ov}); else passed++;
   endtask

   task automatic test_sub8();
      logic [7:0] r; logic co, ov; int lat;
      run8(8'h05, 8'h07, 1'b0, 1'b1, r, co, ov, lat);
      total++; if (lat !== 4) $display("FAIL sub_latency: got %0d want 4", lat); else passed++;
      total++; if (r !== 8'hFE) $display("FAIL sub1_res: got %h want fe", r); else passed++;
      total++; if ({co, ov} !== 2'b10) $display("FAIL sub1_flags: got %b want 10", {co, ov}); else passed++;
      run8(8'h80, 8'h01, 1'b0, 1'b1, r, co, ov, lat);
      total++; if (r !== 8'h7F) $display("FAIL sub2_res: got %h want 7f", r); else passed++;
      total++; if ({co, ov} !== 2'b01) $display("FAIL sub2_flags: got %b want 01", {co, ov}); else passed++;
      run8(8'h10, 8'h01, 1'b1, 1'b1, r, co, ov, lat);
      total++; if (r !== 8'h0E) $display("FAIL sub3_res: got %h want 0e", r); else passed++;
      total++; if ({co, ov} !== 2'b00) $display("FAIL sub3_flags: got %b want 00", {co, ov}); else passed++;
      run8(8'h00, 8'h00, 1'b1, 1'b1, r, co, ov, lat);
      total++; if (r !== 8'hFF) $display("FAIL sub4_res: got %h want ff", r); else passed++;
      total++; if ({co, ov} !== 2'b10) $display("FAIL sub4_flags: got %b want 10", {co, ov}); else passed++;
   endtask

   task automatic test_add8();
      logic [7:0] r; logic co, ov; int lat;
      run8(8'hFF, 8'h01, 1'b0, 1'b0, r, co, ov, lat);
      total++; if (r !== 8'h00) $display("FAIL add1_res: got %h want 00", r); else passed++;
      total++; if ({co, ov} !== 2'b10) $display("FAIL add1_flags: got %b want 10", {co, ov}); else passed++;
      run8(8'h7F, 8'h7F, 1'b1, 1'b0, r, co, ov, lat);
      total++; if (r !== 8'hFF) $display("FAIL add2_res: got %h want ff", r); else passed++;
      total++; if ({co, ov} !== 2'b01) $display("FAIL add2_flags: got %b want 01", {co, ov}); else passed++;
   endtask

   task automatic test_backpressure();
      int n;
      v8_a = 8'h05; v8_b = 8'h07; v8_cin = 1'b0; v8_sub = 1'b0; v8_in_valid = 1'b1;
      @(posedge clk); #1;
      v8_in_valid = 1'b0;
      n = 0;
      while (!v8_out_valid && n < 50) begin @(posedge clk); #1; n++; end
      total++; if (n !== 4) $display("FAIL bp_latency: got %0d want 4", n); else passed++;
      v8_a = 8'hAA; v8_b = 8'h55; v8_in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         total++; if ({v8_out_valid, v8_in_ready} !== 2'b10) $display("FAIL bp_hs_%0d: got %b want 10", i, {v8_out_valid, v8_in_ready}); else passed++;
         total++; if ({v8_res, v8_cout, v8_ovf} !== {8'h0C, 2'b00}) $display("FAIL bp_hold_%0d: got %h want 030", i, {v8_res, v8_cout, v8_ovf}); else passed++;
      end
      v8_in_valid = 1'b0; v8_out_ready = 1'b1;
      @(posedge clk); #1;
      v8_out_ready = 1'b0;
      total++; if ({v8_in_ready, v8_out_valid} !== 2'b10) $display("FAIL bp_release: got %b want 10", {v8_in_ready, v8_out_valid}); else passed++;
      repeat (5) begin @(posedge clk); #1; end
      total++; if (v8_out_valid !== 1'b0) $display("FAIL bp_no_stray: got %b want 0", v8_out_valid); else passed++;
   endtask

   task automatic test_change_during_run();
      int n;
      v8_a = 8'h05; v8_b = 8'h02; v8_cin = 1'b0; v8_sub = 1'b0; v8_in_valid = 1'b1;
      @(posedge clk); #1;
      v8_in_valid = 1'b0; v8_a = 8'hFF; v8_b = 8'hFF; v8_cin = 1'b1; v8_sub = 1'b1;
      n = 0;
      while (!v8_out_valid && n < 50) begin @(posedge clk); #1; n++; end
      total++; if (v8_res !== 8'h07) $display("FAIL chg_res: got %h want 07", v8_res); else passed++;
      total++; if ({v8_cout, v8_ovf} !== 2'b00) $display("FAIL chg_flags: got %b want 00", {v8_cout, v8_ovf}); else passed++;
      v8_out_ready = 1'b1;
      @(posedge clk); #1;
      v8_out_ready = 1'b0; v8_cin = 1'b0; v8_sub = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      logic [7:0] r; logic co, ov; int lat;
      v8_a = 8'h33; v8_b = 8'h11; v8_cin = 1'b0; v8_sub = 1'b0; v8_in_valid = 1'b1;
      @(posedge clk); #1;
      v8_in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      total++; if ({v8_out_valid, v8_in_ready} !== 2'b00) $display("FAIL mid_rst_hs: got %b want 00", {v8_out_valid, v8_in_ready}); else passed++;
      total++; if (v8_res !== 8'h00) $display("FAIL mid_rst_res: got %h want 00", v8_res); else passed++;
      rst = 1'b0;
      #1;
      total++; if (v8_in_ready !== 1'b1) $display("FAIL mid_rst_ready: got %b want 1", v8_in_ready); else passed++;
      repeat (4) begin @(posedge clk); #1; end
      total++; if (v8_out_valid !== 1'b0) $display("FAIL mid_rst_discard: got %b want 0", v8_out_valid); else passed++;
      run8(8'h10, 8'h20, 1'b0, 1'b0, r, co, ov, lat);
      total++; if (lat !== 4) $display("FAIL fresh_latency: got %0d want 4", lat); else passed++;
      total++; if ({r, co, ov} !== {8'h30, 2'b00}) $display("FAIL fresh_result: got %h want 0c0", {r, co, ov}); else passed++;
   endtask

   task automatic test_back_to_back();
      int pulses;
      int cyc;
      v8_a = 8'h21; v8_b = 8'h12; v8_cin = 1'b0; v8_sub = 1'b0;
      v8_in_valid = 1'b1; v8_out_ready = 1'b1;
      pulses = 0; cyc = 0;
      while (pulses < 3 && cyc < 60) begin
         @(posedge clk); #1; cyc++;
         if (v8_out_valid) begin
            pulses++;
            total++; if ({v8_res, v8_in_ready} !== {8'h33, 1'b0}) $display("FAIL b2b_%0d: got %h want 66", pulses, {v8_res, v8_in_ready}); else passed++;
            if (pulses == 3) v8_in_valid = 1'b0;
         end
      end
      @(posedge clk); #1;
      v8_out_ready = 1'b0;
      total++; if (pulses !== 3) $display("FAIL b2b_count: got %0d want 3", pulses); else passed++;
      total++; if ({v8_out_valid, v8_in_ready} !== 2'b01) $display("FAIL b2b_idle: got %b want 01", {v8_out_valid, v8_in_ready}); else passed++;
   endtask

   initial begin
      rst = 1'b1;
      v8_in_valid = 1'b0; v8_out_ready = 1'b0; v8_a = '0; v8_b = '0; v8_cin = 1'b0; v8_sub = 1'b0;
      q1_in_valid = 1'b0; q1_out_ready = 1'b0; q1_a = '0; q1_b = '0; q1_cin = 1'b0; q1_sub = 1'b0;
      q2_in_valid = 1'b0; q2_out_ready = 1'b0; q2_a = '0; q2_b = '0; q2_cin = 1'b0; q2_sub = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_w4_d1();
      test_w4_d2();
      test_sub8();
      test_add8();
      test_backpressure();
      test_change_during_run();
      test_reset_mid_run();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
